// File: rtl/pp_tile_loader_pkg.sv
// Shared types and sizing helpers for the ping-pong tile loader.
package pp_tile_loader_pkg;

   localparam int W_IN_WIDTH = 64;
   localparam int N_IN_WIDTH = 64;

   typedef enum logic {
      FILL,
      WAIT
   } ld_state_e;

   function automatic int beats_w(int ninst, int tw);
      return ninst * tw;
   endfunction

   function automatic int beats_tile(int ninst, int tw, int tn);
      return ninst * (tw + tn);
   endfunction

   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pp_tile_loader_beat_addr_gen.sv
// Beat address generator: phase (west/north), instance and element
// counters walking one tile, with wrap on the last beat and resync clear.
module pp_beat_addr_gen
   import pp_tile_loader_pkg::*;
#(
   parameter int NUM_INST        = 4,
   parameter int TOTAL_INPUT_W_W = 2,
   parameter int TOTAL_INPUT_W_N = 2,
   parameter int IW              = idx_w(NUM_INST),
   parameter int EW              = idx_w(max2(TOTAL_INPUT_W_W, TOTAL_INPUT_W_N))
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adv_i,
   input  logic          clr_i,
   output logic          phase_o,
   output logic [IW-1:0] inst_o,
   output logic [EW-1:0] elem_o,
   output logic          last_o
);

   localparam logic [IW-1:0] INST_MAX = IW'(NUM_INST - 1);
   localparam logic [EW-1:0] W_MAX    = EW'(TOTAL_INPUT_W_W - 1);
   localparam logic [EW-1:0] N_MAX    = EW'(TOTAL_INPUT_W_N - 1);

   logic          phase_q, phase_d;
   logic [IW-1:0] inst_q, inst_d;
   logic [EW-1:0] elem_q, elem_d;
   logic [EW-1:0] elem_max;

   always_comb begin
      phase_d  = phase_q;
      inst_d   = inst_q;
      elem_d   = elem_q;
      elem_max = phase_q ? N_MAX : W_MAX;
      if (clr_i) begin
         phase_d = 1'b0;
         inst_d  = '0;
         elem_d  = '0;
      end else if (adv_i) begin
         if (elem_q != elem_max) begin
            elem_d = elem_q + 1'b1;
         end else begin
            elem_d = '0;
            if (inst_q != INST_MAX) begin
               inst_d = inst_q + 1'b1;
            end else begin
               inst_d  = '0;
               phase_d = ~phase_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         inst_q  <= '0;
         elem_q  <= '0;
      end else begin
         phase_q <= phase_d;
         inst_q  <= inst_d;
         elem_q  <= elem_d;
      end
   end

   assign phase_o = phase_q;
   assign inst_o  = inst_q;
   assign elem_o  = elem_q;
   assign last_o  = phase_q && (inst_q == INST_MAX) && (elem_q == N_MAX);

endmodule

// File: rtl/pp_tile_loader.sv
// Stream-to-tile loader feeding alternating ping-pong din banks.
// Optional tlast framing check: PP_TILE_LOADER_TLAST_CHECK_EN.
module pp_tile_loader
   import pp_tile_loader_pkg::*;
#(
   parameter int NUM_INST        = 4,
   parameter int TOTAL_INPUT_W_W = 2,
   parameter int TOTAL_INPUT_W_N = 2,
   parameter int DATA_WIDTH      = W_IN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic                  load_ready,
   output logic [DATA_WIDTH-1:0] w_bank0_din [NUM_INST][TOTAL_INPUT_W_W],
   output logic [DATA_WIDTH-1:0] w_bank1_din [NUM_INST][TOTAL_INPUT_W_W],
   output logic [DATA_WIDTH-1:0] n_bank0_din [NUM_INST][TOTAL_INPUT_W_N],
   output logic [DATA_WIDTH-1:0] n_bank1_din [NUM_INST][TOTAL_INPUT_W_N],
   output logic                  in_valid,
   output logic                  bank_sel,
   output logic [15:0]           tiles_loaded,
   output logic                  framing_err
);

   localparam int IW = idx_w(NUM_INST);
   localparam int EW = idx_w(max2(TOTAL_INPUT_W_W, TOTAL_INPUT_W_N));

   typedef logic [DATA_WIDTH-1:0] w_arr_t [NUM_INST][TOTAL_INPUT_W_W];
   typedef logic [DATA_WIDTH-1:0] n_arr_t [NUM_INST][TOTAL_INPUT_W_N];

   ld_state_e     state_q, state_d;
   logic          rdy_q;
   logic          sel_q, nxt_q, iv_q;
   logic [15:0]   tiles_q;
   w_arr_t        w_stg_q, w0_q, w1_q;
   n_arr_t        n_stg_q, n0_q, n1_q;

   logic          hs, early, miss, wr_en, load;
   logic          phase, last;
   logic [IW-1:0] inst;
   logic [EW-1:0] elem;

   assign hs = s_tvalid && rdy_q;

`ifdef PP_TILE_LOADER_TLAST_CHECK_EN
   logic ferr_q;

   assign early = hs && s_tlast && !last;
   assign miss  = hs && !s_tlast && last;

   always_ff @(posedge clk) begin
      if (!rst_n) ferr_q <= 1'b0;
      else if (early || miss) ferr_q <= 1'b1;
   end

   assign framing_err = ferr_q;
`else
   logic tlast_unused;

   assign tlast_unused = s_tlast;
   assign early        = 1'b0;
   assign miss         = 1'b0;
   assign framing_err  = 1'b0;
`endif

   // A premature tlast drops its beat and resyncs to beat 0
   assign wr_en = hs && !early;

   pp_beat_addr_gen #(
      .NUM_INST       (NUM_INST),
      .TOTAL_INPUT_W_W(TOTAL_INPUT_W_W),
      .TOTAL_INPUT_W_N(TOTAL_INPUT_W_N),
      .IW             (IW),
      .EW             (EW)
   ) u_addr (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (wr_en),
      .clr_i  (early),
      .phase_o(phase),
      .inst_o (inst),
      .elem_o (elem),
      .last_o (last)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         FILL: if (wr_en && last) state_d = WAIT;
         WAIT: begin
            if (load_ready) begin
               state_d = FILL;
               load    = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
         rdy_q   <= 1'b0;
         sel_q   <= 1'b0;
         nxt_q   <= 1'b0;
         iv_q    <= 1'b0;
         tiles_q <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d == FILL);
         iv_q    <= load;
         if (load) begin
            sel_q   <= nxt_q;
            nxt_q   <= ~nxt_q;
            tiles_q <= tiles_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_stg_q <= '{default: '0};
         n_stg_q <= '{default: '0};
      end else if (wr_en) begin
         if (!phase) w_stg_q[inst][elem] <= s_tdata;
         else        n_stg_q[inst][elem] <= s_tdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w0_q <= '{default: '0};
         w1_q <= '{default: '0};
         n0_q <= '{default: '0};
         n1_q <= '{default: '0};
      end else if (load) begin
         if (!nxt_q) begin
            w0_q <= w_stg_q;
            n0_q <= n_stg_q;
         end else begin
            w1_q <= w_stg_q;
            n1_q <= n_stg_q;
         end
      end
   end

   assign s_tready     = rdy_q;
   assign in_valid     = iv_q;
   assign bank_sel     = sel_q;
   assign tiles_loaded = tiles_q;
   assign w_bank0_din  = w0_q;
   assign w_bank1_din  = w1_q;
   assign n_bank0_din  = n0_q;
   assign n_bank1_din  = n1_q;

endmodule

// File: tb/tb_pp_tile_loader.sv
// Directed + random bench for pp_tile_loader against a beat-index model.
module tb_pp_tile_loader;
   import pp_tile_loader_pkg::*;

   localparam int NI = 4;
   localparam int TW = 2;
   localparam int TN = 2;
   localparam int DW = 64;
   localparam int BW = beats_w(NI, TW);
   localparam int BT = beats_tile(NI, TW, TN);
`ifdef PP_TILE_LOADER_TLAST_CHECK_EN
   localparam bit TLAST = 1'b1;
`else
   localparam bit TLAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid, s_tready, s_tlast, load_ready;
   logic [DW-1:0] w_bank0_din [NI][TW];
   logic [DW-1:0] w_bank1_din [NI][TW];
   logic [DW-1:0] n_bank0_din [NI][TN];
   logic [DW-1:0] n_bank1_din [NI][TN];
   logic          in_valid, bank_sel, framing_err;
   logic [15:0]   tiles_loaded;

   pp_tile_loader #(
      .NUM_INST(NI), .TOTAL_INPUT_W_W(TW),
      .TOTAL_INPUT_W_N(TN), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .s_tlast(s_tlast),
      .load_ready(load_ready),
      .w_bank0_din(w_bank0_din), .w_bank1_din(w_bank1_din),
      .n_bank0_din(n_bank0_din), .n_bank1_din(n_bank1_din),
      .in_valid(in_valid), .bank_sel(bank_sel),
      .tiles_loaded(tiles_loaded), .framing_err(framing_err)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   // reference model: flat beat index into a staged tile, two banks
   bit            m_rdy, m_wait, m_iv, m_sel, m_nxt, m_ferr;
   int            m_b;
   logic [15:0]   m_tiles;
   logic [DW-1:0] stg [BT];
   logic [DW-1:0] mw [2][NI][TW];
   logic [DW-1:0] mn [2][NI][TN];

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit hs;
      int k;
      if (!rst_n) begin
         m_rdy = 0; m_wait = 0; m_iv = 0; m_sel = 0; m_nxt = 0;
         m_ferr = 0; m_b = 0; m_tiles = '0;
         for (int b = 0; b < BT; b++) stg[b] = '0;
         for (int bk = 0; bk < 2; bk++)
            for (int i = 0; i < NI; i++) begin
               for (int e = 0; e < TW; e++) mw[bk][i][e] = '0;
               for (int e = 0; e < TN; e++) mn[bk][i][e] = '0;
            end
         return;
      end
      hs   = s_tvalid && m_rdy;
      m_iv = 0;
      if (!m_wait) begin
         if (hs) begin
            if (TLAST && s_tlast && m_b != BT-1) begin
               m_ferr = 1;
               m_b    = 0;
            end else begin
               if (TLAST && !s_tlast && m_b == BT-1) m_ferr = 1;
               stg[m_b] = s_tdata;
               if (m_b == BT-1) begin
                  m_b    = 0;
                  m_wait = 1;
               end else m_b++;
            end
         end
      end else if (load_ready) begin
         for (int b = 0; b < BT; b++) begin
            if (b < BW) mw[m_nxt][b / TW][b % TW] = stg[b];
            else begin
               k = b - BW;
               mn[m_nxt][k / TN][k % TN] = stg[b];
            end
         end
         m_sel   = m_nxt;
         m_nxt   = !m_nxt;
         m_tiles = m_tiles + 16'd1;
         m_iv    = 1;
         m_wait  = 0;
      end
      m_rdy = !m_wait;
   endtask

   task automatic compare_all();
      chk("s_tready", s_tready, m_rdy);
      chk("in_valid", in_valid, m_iv);
      chk("bank_sel", bank_sel, m_sel);
      chk("tiles_loaded", tiles_loaded, m_tiles);
      chk("framing_err", framing_err, m_ferr);
      for (int i = 0; i < NI; i++) begin
         for (int e = 0; e < TW; e++) begin
            chk("w_bank0_din", w_bank0_din[i][e], mw[0][i][e]);
            chk("w_bank1_din", w_bank1_din[i][e], mw[1][i][e]);
         end
         for (int e = 0; e < TN; e++) begin
            chk("n_bank0_din", n_bank0_din[i][e], mn[0][i][e]);
            chk("n_bank1_din", n_bank1_din[i][e], mn[1][i][e]);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic send_beat(logic [DW-1:0] d, bit last);
      bit hs;
      int n;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      n = 0;
      do begin
         hs = m_rdy;
         step();
         n++;
         if (n > 200) begin
            chk("beat_timeout", s_tready, 1'b1);
            $display("%0d/%0d checks passed", npass, ntot);
            $fatal(1, "FAIL beat_timeout: no handshake");
         end
      end while (!hs);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_tile(logic [DW-1:0] base, bit toggle);
      for (int b = 0; b < BT; b++) begin
         if (toggle) step();
         send_beat(base + DW'(b), b == BT-1);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      s_tvalid   = 1'b0;
      s_tdata    = '0;
      s_tlast    = 1'b0;
      load_ready = 1'b0;
      step();
      step();
      chk("reset_tready", s_tready, 1'b0);
      rst_n = 1'b1;
      step();
      chk("post_reset_tready", s_tready, 1'b1);

      load_ready = 1'b1;
      send_tile(64'h00, 1'b0);
      step();
      chk("t1_pulse", in_valid, 1'b1);
      step();
      chk("t1_w00", w_bank0_din[0][0], 64'h00);
      chk("t1_w31", w_bank0_din[3][1], 64'h07);
      chk("t1_n00", n_bank0_din[0][0], 64'h08);
      chk("t1_n31", n_bank0_din[3][1], 64'h0F);
      chk("t1_sel", bank_sel, 1'b0);

      send_tile(64'h10, 1'b0);
      step();
      step();
      chk("t2_w00", w_bank1_din[0][0], 64'h10);
      chk("t2_b0_kept", w_bank0_din[3][1], 64'h07);
      chk("t2_sel", bank_sel, 1'b1);
      chk("t2_tiles", tiles_loaded, 16'd2);

      load_ready = 1'b0;
      send_tile(64'h20, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("hold_tready", s_tready, 1'b0);
         chk("hold_valid", in_valid, 1'b0);
      end
      load_ready = 1'b1;
      step();
      chk("hold_pulse", in_valid, 1'b1);
      step();

      send_tile(64'h00, 1'b1);
      step();
      chk("tog_pulse", in_valid, 1'b1);
      chk("tog_w31", w_bank1_din[3][1], 64'h07);
      chk("tog_n31", n_bank1_din[3][1], 64'h0F);
      step();

      for (int b = 0; b < 10; b++) send_beat(64'h30 + DW'(b), 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_valid", in_valid, 1'b0);
      chk("rst_w31", w_bank1_din[3][1], 64'h0);
      chk("rst_tiles", tiles_loaded, 16'd0);
      send_tile(64'h40, 1'b0);
      step();
      step();
      chk("rst_tile_w31", w_bank0_din[3][1], 64'h47);
      chk("rst_tile_sel", bank_sel, 1'b0);

`ifdef PP_TILE_LOADER_TLAST_CHECK_EN
      for (int b = 0; b < 5; b++) send_beat(64'h50 + DW'(b), 1'b0);
      send_beat(64'h55, 1'b1);
      chk("ferr_set", framing_err, 1'b1);
      send_tile(64'h60, 1'b0);
      step();
      step();
      chk("ferr_w00", w_bank1_din[0][0], 64'h60);
      chk("ferr_n31", n_bank1_din[3][1], 64'h6F);
      chk("ferr_sticky", framing_err, 1'b1);
`endif

      for (int c = 0; c < 800; c++) begin
         s_tvalid   = ($urandom_range(0, 3) != 0);
         s_tdata    = {$urandom, $urandom};
         load_ready = $urandom_range(0, 1) != 0;
         s_tlast    = (m_b == BT-1);
         step();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/pp_tile_loader.md
Name: pp_tile_loader

Overview:
- Upstream feeder for the ping-pong buffer top.
- Accepts a single AXI-Stream-style word stream and assembles one complete tile: west words for every buffer instance, then north words for every buffer instance.
- Drives the bank0/bank1 din arrays with the assembled tile, alternating banks per tile, and pulses in_valid to the ping-pong controller.
- Holds off input (s_tready low) until the controller side signals it can take the next tile.

Parameters:
- NUM_INST, 4, number of buffer instances fed in parallel.
- TOTAL_INPUT_W_W, 2, west words per instance per tile.
- TOTAL_INPUT_W_N, 2, north words per instance per tile.
- DATA_WIDTH, 64, stream word width; equals W_IN_WIDTH and N_IN_WIDTH.
- BEATS_W, NUM_INST*TOTAL_INPUT_W_W (derived), west beats per tile.
- BEATS_TILE, NUM_INST*(TOTAL_INPUT_W_W+TOTAL_INPUT_W_N) (derived), beats per tile (16 at defaults).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- s_tdata  in  DATA_WIDTH  stream word.
- s_tvalid  in  1  word valid.
- s_tready  out  1  loader accepts a word this cycle.
- s_tlast  in  1  last word of tile (checked only with the optional feature).
- load_ready  in  1  downstream can accept a new tile (from controller/top).
- w_bank0_din  out  DATA_WIDTH x [NUM_INST][TOTAL_INPUT_W_W]  west data, bank0.
- w_bank1_din  out  same  west data, bank1.
- n_bank0_din  out  DATA_WIDTH x [NUM_INST][TOTAL_INPUT_W_N]  north data, bank0.
- n_bank1_din  out  same  north data, bank1.
- in_valid  out  1  one-cycle pulse: tile present on the bank given by bank_sel.
- bank_sel  out  1  bank targeted by the current or most recent in_valid.
- tiles_loaded  out  16  wrapping count of issued tiles.
- framing_err  out  1  sticky framing error.

Behaviour:
- Reset (rst_n low at a clk edge) forces:
  - state FILL, beat counter 0, bank_sel 0, next bank 0.
  - All din registers and the staging array 0.
  - in_valid 0, tiles_loaded 0, framing_err 0.
  - s_tready 0 during the reset cycle; 1 in the first cycle after.
- Reset mid-tile discards the partial tile; no in_valid is produced for it.
- A handshake occurs when s_tvalid && s_tready at a rising edge.
- Beat order within a tile, for beat index b:
  - b < BEATS_W: west word; inst = b / TOTAL_INPUT_W_W, elem = b % TOTAL_INPUT_W_W.
  - Otherwise: north word; b' = b - BEATS_W, inst = b' / TOTAL_INPUT_W_N, elem = b' % TOTAL_INPUT_W_N.
  - Implemented with separate phase/inst/elem counters (no dividers).
- FSM states:
  - FILL: s_tready = 1; each handshake writes the staging array. Handshake at b = BEATS_TILE-1 → WAIT; counters wrap to 0.
  - WAIT: s_tready = 0. When load_ready = 1:
    - Copy staging into the din arrays of the next bank; the other bank's din is untouched.
    - Set bank_sel = next bank.
    - Register in_valid = 1 for exactly the following cycle, with din already stable in that cycle.
    - Toggle next bank; increment tiles_loaded (wraps 0xFFFF→0).
    - → FILL.
  - If load_ready is 1 on the same edge the last beat is accepted, the tile still spends one cycle in WAIT. Minimum inter-tile gap: BEATS_TILE+1 cycles.
- din registers hold their value until overwritten by a later tile to the same bank.
- s_tvalid low mid-tile: counters hold; no timeout.
- s_tready is a registered function of state, not combinational from load_ready.

Optional Feature:
- Macro: PP_TILE_LOADER_TLAST_CHECK_EN.
- Defined:
  - s_tlast on beat BEATS_TILE-1 is required.
  - s_tlast high on any earlier beat → framing_err sets (sticky until reset); the beat is dropped; counters return to 0 (resync); no in_valid.
  - s_tlast low on the final beat → framing_err sets, but the tile is issued normally.
- Undefined: s_tlast ignored; framing_err tied 0.

Decomposition:
- Shared package (alongside the existing ping-pong package):
  - State enum typedef (FILL, WAIT).
  - BEATS_W / BEATS_TILE derivation functions.
  - DATA_WIDTH default tied to W_IN_WIDTH/N_IN_WIDTH.
- One natural sub-module: pp_beat_addr_gen, holding the phase/inst/elem counters with wrap and resync clear.
- Staging array, FSM and bank copy stay in the top of this block.

Test Plan:
- Reset then 16 beats with data 0x00..0x0F, load_ready = 1 →
  - w_bank0_din[0][0] = 0x00, w_bank0_din[3][1] = 0x07, n_bank0_din[0][0] = 0x08, n_bank0_din[3][1] = 0x0F.
  - in_valid is a single pulse at cycle 18 after the first beat; bank_sel = 0.
- Second tile 0x10..0x1F → lands in bank1; bank0 din unchanged; bank_sel = 1; tiles_loaded = 2.
- load_ready held 0 for 10 cycles after the last beat →
  - s_tready stays 0 and in_valid stays 0 for those cycles.
  - The pulse comes the cycle after load_ready rises.
- s_tvalid toggling 1/0 every cycle →
  - Tile still assembles in order (same expected values as the first scenario).
  - in_valid comes after 32 cycles plus the WAIT cycle.
- rst_n low for 1 cycle after beat 9 of a tile →
  - No in_valid; all din return to 0.
  - The next 16 beats form a full tile into bank0.
- With PP_TILE_LOADER_TLAST_CHECK_EN defined, s_tlast on beat 5 →
  - framing_err = 1 (sticky); the beat is dropped.
  - The next 16 beats with s_tlast on beat 15 issue a correct tile.
